// File: rtl/cereal_rx.sv
// cereal_rx: 8N1 serial receiver feeding a small first-word-fall-through FIFO.
//   sysclk    - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   rx        - serial line, idle high, asynchronous to sysclk
//   rd        - pop request, honoured only while valid=1
//   clr       - clears the sticky overrun flag
//   data      - FIFO head byte (holds last head when empty)
//   valid     - FIFO not empty
//   frame_err - one-cycle pulse when a stop bit is sampled low
//   overrun   - sticky, a received byte was dropped on a full FIFO
//   busy      - receiver FSM is not idle
//
// state | meaning
// IDLE  | waiting for the line to go low
// START | counting to mid start bit to reject glitches
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit
// BRK   | stop bit was low; waiting for the line to return high
module cereal_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd,
  input  logic       clr,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int NW  = PW + 1;
  localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t state, state_nxt;

  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          bit_tc, stop_ok, stop_bad, push_pend;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic [7:0]    hold;
  logic          empty, full, pop, push_ok, drop;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign bit_tc = (cnt == BIT_TC);

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (cnt == HALF_TC) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_tc && idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_tc) state_nxt = rx_s ? IDLE : BRK;
      BRK:     if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    stop_ok  = (state == STOP) && bit_tc && rx_s;
    stop_bad = (state == STOP) && bit_tc && !rx_s;
  end

  // Cycle counter restarts on every state change and on each data bit sample.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      push_pend <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      push_pend <= stop_ok;
      frame_err <= stop_bad;
      if (state != state_nxt || (state == DATA && bit_tc))
        cnt <= '0;
      else if (state == START || state == DATA || state == STOP)
        cnt <= cnt + CW'(1);
      else
        cnt <= '0;
      if (state == IDLE)
        idx <= '0;
      else if (state == DATA && bit_tc) begin
        shreg[idx] <= rx_s;
        idx        <= idx + 3'd1;
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == NW'(FIFO_DEPTH));
  assign pop     = rd && !empty;
  assign push_ok = push_pend && (!full || pop);
  assign drop    = push_pend && full && !pop;
  assign valid   = !empty;
  // hold tracks the head while non-empty so data keeps the last head after draining.
  assign data    = empty ? hold : mem[rd_ptr];

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      hold    <= '0;
      overrun <= 1'b0;
    end else begin
      hold <= data;
      if (push_ok) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + NW'(1);
      else if (pop && !push_ok) count <= count - NW'(1);
      if (drop)     overrun <= 1'b1;
      else if (clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cereal_rx.sv
module tb_cereal_rx;

  localparam int C = 16;
  localparam int D = 4;

  logic       sysclk = 1'b0;
  logic       rst_n, rx, rd, clr;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  int   errors = 0;
  int   checks = 0;
  int   fe_pulses = 0;
  int   fe_high = 0;
  logic fe_prev = 1'b0;
  bit   exp_ovr = 1'b0;
  logic [7:0] exp_q[$];

  cereal_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .sysclk(sysclk), .rst_n(rst_n), .rx(rx), .rd(rd), .clr(clr),
    .data(data), .valid(valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted pop is compared against the model queue.
  always @(negedge sysclk) begin
    #1;
    if (rst_n && rd && valid) begin
      if (exp_q.size() == 0) check("unexpected_pop", {24'h0, data}, 32'hFFFF_FFFF);
      else check("pop_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
    end
    if (frame_err) fe_high++;
    if (frame_err && !fe_prev) fe_pulses++;
    fe_prev = frame_err;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  // Drives one frame; optionally raises rd in the cycle the byte is pushed
  // (first cycle after busy drops during the stop bit).
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit rd_at_push);
    logic [9:0] bits;
    bit prev_busy;
    bit done_rd;
    bits = {stop, b, 1'b0};
    prev_busy = 1'b0;
    done_rd = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int k = 0; k < C; k++) begin
        @(negedge sysclk);
        rd = 1'b0;
        if (rd_at_push && !done_rd && i == 9 && prev_busy && !busy) begin
          rd = 1'b1;
          done_rd = 1'b1;
        end
        prev_busy = busy;
      end
    end
    rd = 1'b0;
    if (rd_at_push && !done_rd) check("push_cycle_seen", 0, 1);
    if (stop) begin
      if (exp_q.size() < D) exp_q.push_back(b);
      else exp_ovr = 1'b1;
    end
  endtask

  task automatic pop_one();
    int t;
    t = 0;
    while (!valid && t < 50) begin
      @(negedge sysclk);
      t++;
    end
    if (!valid) check("pop_timeout", {31'h0, valid}, 1);
    else begin
      rd = 1'b1;
      @(negedge sysclk);
      rd = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'h0, valid}, 0);
    check({tag, "_data"}, {24'h0, data}, 0);
    check({tag, "_busy"}, {31'h0, busy}, 0);
    check({tag, "_frame_err"}, {31'h0, frame_err}, 0);
    check({tag, "_overrun"}, {31'h0, overrun}, 0);
  endtask

  initial begin
    int bc;
    int n;
    rx = 1'b1; rd = 1'b0; clr = 1'b0; rst_n = 1'b0;
    wait_cycles(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    wait_cycles(5);

    // Single byte
    send_frame(8'h41, 1'b1, 1'b0);
    check("a_valid", {31'h0, valid}, 1);
    check("a_data", {24'h0, data}, 32'h41);
    pop_one();
    wait_cycles(2);
    check("a_valid_after_rd", {31'h0, valid}, 0);
    check("a_overrun", {31'h0, overrun}, 0);
    check("a_frame_err", fe_pulses, 0);

    // Start-bit glitch
    bc = 0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 6) rx = 1'b1;
      @(negedge sysclk);
      if (busy) bc++;
    end
    check("glitch_busy_cycles", bc, 8);
    check("glitch_no_push", {31'h0, valid}, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("g_data", {24'h0, data}, 32'h5A);
    pop_one();

    // Framing error with line held low
    send_frame(8'hC3, 1'b0, 1'b0);
    wait_cycles(40);
    rx = 1'b1;
    wait_cycles(20);
    check("fe_pulses", fe_pulses, 1);
    check("fe_width", fe_high, 1);
    check("fe_no_push", {31'h0, valid}, 0);
    check("fe_idle", {31'h0, busy}, 0);
    send_frame(8'h0F, 1'b1, 1'b0);
    check("fe_next_data", {24'h0, data}, 32'h0F);
    pop_one();
    wait_cycles(2);

    // Overrun
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
    check("ovr_set", {31'h0, overrun}, {31'h0, exp_ovr});
    check("ovr_set_abs", {31'h0, overrun}, 1);
    for (int i = 0; i < 4; i++) pop_one();
    wait_cycles(2);
    check("ovr_drained", {31'h0, valid}, 0);
    check("ovr_sticky", {31'h0, overrun}, 1);
    clr = 1'b1;
    @(negedge sysclk);
    clr = 1'b0;
    exp_ovr = 1'b0;
    wait_cycles(1);
    check("ovr_clr", {31'h0, overrun}, 0);

    // Full FIFO with pop in the push cycle
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b1);
    check("full_pop_no_ovr", {31'h0, overrun}, 0);
    check("full_pop_depth", exp_q.size(), 4);
    for (int i = 0; i < 4; i++) pop_one();
    wait_cycles(2);
    check("full_pop_drained", {31'h0, valid}, 0);
    check("full_pop_hold", {24'h0, data}, 32'hAA);

    // Reset during data bit 4 of 8'hFF
    rx = 1'b0;
    wait_cycles(C);
    rx = 1'b1;
    wait_cycles(4 * C + C / 2);
    rst_n = 1'b0;
    wait_cycles(2);
    check_reset_outputs("midrst");
    exp_q.delete();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(20);
    check("midrst_nothing", {31'h0, valid}, 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    check("midrst_data", {24'h0, data}, 32'h3C);
    pop_one();
    wait_cycles(2);
    check("midrst_only_one", {31'h0, valid}, 0);

    // Random bytes with random draining
    for (int i = 0; i < 12; i++) begin
      send_frame(8'($urandom), 1'b1, 1'b0);
      check("rnd_overrun", {31'h0, overrun}, {31'h0, exp_ovr});
      n = $urandom_range(0, 2);
      for (int k = 0; k < n; k++) if (exp_q.size() > 0) pop_one();
    end
    n = exp_q.size();
    for (int k = 0; k < n; k++) pop_one();
    wait_cycles(2);
    check("rnd_drained", {31'h0, valid}, 0);
    check("rnd_model_empty", exp_q.size(), 0);
    check("final_fe_pulses", fe_pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
